// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int KEY_W    = 4;
    localparam int FRAME_W  = NUM_ROWS * NUM_COLS;

    // Sampling is folded into the last DRIVE dwell cycle, so only two states exist.
    typedef enum logic {
        DRIVE,
        EVAL
    } scan_state_t;

    typedef enum logic [1:0] {
        NONE,
        SINGLE,
        MULTI
    } frame_class_t;

    // Key index as seen downstream: {row[1:0], col[1:0]}.
    function automatic logic [KEY_W-1:0] key_index(input int r, input int c);
        return KEY_W'(r * NUM_COLS + c);
    endfunction

endpackage

// File: rtl/row_sync.sv
// Two-flop synchronizer for asynchronous inputs; resets to all-ones so an
// idle (pulled-up) keypad row reads as released straight out of reset.
module row_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two back-to-back capture stages to settle metastability.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks one active-low column at a time, samples
// the synchronized rows at the end of each column dwell, classifies every
// full frame and debounces across frames before updating the key outputs.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_ROWS-1:0] row_in,
    output logic [NUM_COLS-1:0] col_out,
    output logic [KEY_W-1:0]    buttonNum,
    output logic                valid,
    output logic                press
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] STAB_MAX   = SW'(DEBOUNCE_CNT);

    logic [NUM_ROWS-1:0] row_s;

    scan_state_t         state;
    logic [DW-1:0]       dwell;
    logic [1:0]          col;
    logic [FRAME_W-1:0]  frame;
    logic [FRAME_W-1:0]  frame_nxt;

    frame_class_t        cand_cls;
    logic [KEY_W-1:0]    cand_key;
    logic [SW-1:0]       stab;

    frame_class_t        cls;
    logic [KEY_W-1:0]    fkey;
    logic [4:0]          nset;
    logic                same;
    logic [SW-1:0]       stab_nxt;
    logic                commit;
    logic                dwell_end;

    row_sync #(.WIDTH(NUM_ROWS)) u_row_sync (
        .clk   (clk),
        .reset (reset),
        .d     (row_in),
        .q     (row_s)
    );

    assign dwell_end = (dwell == DWELL_LAST);

    // Merge the current column's pressed rows into the frame vector.
    always_comb begin
        frame_nxt = frame;
        for (int r = 0; r < NUM_ROWS; r++) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                if (col == 2'(c))
                    frame_nxt[key_index(r, c)] = ~row_s[r];
            end
        end
    end

    // Classify the completed frame: count set bits and remember the last one.
    always_comb begin
        nset = '0;
        fkey = '0;
        for (int i = 0; i < FRAME_W; i++) begin
            if (frame[i]) begin
                nset = nset + 5'd1;
                fkey = KEY_W'(i);
            end
        end
        if (nset == 5'd0)
            cls = NONE;
        else if (nset == 5'd1)
            cls = SINGLE;
        else
            cls = MULTI;
    end

    // Debounce step: a key index only distinguishes SINGLE frames.
    always_comb begin
        same = (cls == cand_cls) && ((cls != SINGLE) || (fkey == cand_key));
        if (!same)
            stab_nxt = SW'(1);
        else if (stab == STAB_MAX)
            stab_nxt = STAB_MAX;
        else
            stab_nxt = stab + SW'(1);
        commit = (stab_nxt == STAB_MAX);
    end

    // Scan FSM with dwell/column counters, frame capture, debounce and outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= DRIVE;
            dwell     <= '0;
            col       <= 2'd0;
            col_out   <= 4'b1110;
            frame     <= '0;
            cand_cls  <= NONE;
            cand_key  <= '0;
            stab      <= '0;
            buttonNum <= '0;
            valid     <= 1'b0;
            press     <= 1'b0;
        end else begin
            press <= 1'b0;

            // Dwell counting; the last dwell cycle doubles as the sample slot.
            if (dwell_end) begin
                dwell   <= '0;
                col     <= col + 2'd1;
                col_out <= {col_out[NUM_COLS-2:0], col_out[NUM_COLS-1]};
                frame   <= frame_nxt;
            end else begin
                dwell <= dwell + DW'(1);
            end

            case (state)
                DRIVE: begin
                    if (dwell_end && (col == 2'd3))
                        state <= EVAL;
                end
                EVAL: begin
                    // Overlaps column 0 dwell cycle 0; column 0 is sampled later.
                    state    <= DRIVE;
                    cand_cls <= cls;
                    cand_key <= fkey;
                    stab     <= stab_nxt;
                    if (commit) begin
                        case (cls)
                            SINGLE: begin
                                if (!valid || (buttonNum != fkey)) begin
                                    buttonNum <= fkey;
                                    valid     <= 1'b1;
                                    press     <= 1'b1;
                                end
                            end
                            NONE:    valid <= 1'b0;
                            default: ; // chords leave outputs untouched
                        endcase
                    end
                end
                default: state <= DRIVE;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model drives the rows from the column
// drive and a set of held keys; each expected press is queued when the key
// is applied and checked against the DUT's press pulse.
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] buttonNum;
    logic       valid;
    logic       press;

    logic [15:0] keys = '0;
    logic [3:0]  exp_q[$];
    int          compared   = 0;
    int          mismatched = 0;
    logic        prev_press = 1'b0;
    logic [3:0]  exp_key;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .row_in    (row_in),
        .col_out   (col_out),
        .buttonNum (buttonNum),
        .valid     (valid),
        .press     (press)
    );

    always #5 clk = ~clk;

    // Row r is pulled low when some held key in row r sits on the driven column.
    always_comb begin
        for (int r = 0; r < 4; r++)
            row_in[r] = !(|(keys[r*4 +: 4] & ~col_out));
    end

    // Scoreboard: every press must match the oldest queued key.
    always @(negedge clk) begin
        if (press) begin
            compared++;
            if (prev_press) begin
                mismatched++;
                $display("FAIL press_double: press high two cycles in a row");
            end
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL press_unexpected: got buttonNum=%0d, no press expected", buttonNum);
            end else begin
                exp_key = exp_q.pop_front();
                if (buttonNum !== exp_key) begin
                    mismatched++;
                    $display("FAIL press_key: got buttonNum=%0d, expected %0d", buttonNum, exp_key);
                end
            end
        end
        prev_press <= press;
    end

    task automatic wait_press(input int bound, input string name);
        logic got = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (press) begin
                got = 1'b1;
                break;
            end
        end
        compared++;
        if (!got) begin
            mismatched++;
            $display("FAIL %s: no press within %0d cycles, expected one", name, bound);
        end
    endtask

    task automatic wait_valid_low(input int bound, input string name);
        logic got = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (valid === 1'b0) begin
                got = 1'b1;
                break;
            end
        end
        compared++;
        if (!got) begin
            mismatched++;
            $display("FAIL %s: valid still %b after %0d cycles, expected 0", name, valid, bound);
        end
    endtask

    task automatic wait_col(input logic [3:0] c, input string name);
        logic got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (col_out === c) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            compared++;
            mismatched++;
            $display("FAIL %s: col_out never reached %b", name, c);
        end
    endtask

    task automatic check_outputs(input string name, input logic [3:0] col_e,
                                 input logic [3:0] key_e, input logic v_e, input logic p_e);
        compared++;
        if (col_out !== col_e || buttonNum !== key_e || valid !== v_e || press !== p_e) begin
            mismatched++;
            $display("FAIL %s: got col=%b key=%0d valid=%b press=%b, expected col=%b key=%0d valid=%b press=%b",
                     name, col_out, buttonNum, valid, press, col_e, key_e, v_e, p_e);
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_col;
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check_outputs("reset_state", 4'b1110, 4'd0, 1'b0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            exp_col = ~(4'b0001 << (((i + 1) / 4) % 4));
            compared++;
            if (col_out !== exp_col) begin
                mismatched++;
                $display("FAIL col_walk[%0d]: got %b, expected %b", i, col_out, exp_col);
            end
        end
    endtask

    task automatic test_hold();
        int bad = 0;
        wait_col(4'b0111, "hold_align");
        wait_col(4'b1110, "hold_align");
        keys[9] = 1'b1;
        exp_q.push_back(4'd9);
        wait_press(50, "hold_press");
        check_outputs("hold_outputs", col_out, 4'd9, 1'b1, 1'b1);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (press !== 1'b0 || valid !== 1'b1 || buttonNum !== 4'd9) bad++;
        end
        compared++;
        if (bad != 0) begin
            mismatched++;
            $display("FAIL hold_steady: %0d bad cycles, expected 0", bad);
        end
    endtask

    task automatic test_bounce();
        keys[9] = 1'b0;
        wait_valid_low(67, "bounce_release");
        for (int i = 0; i < 80; i++) begin
            if (i % 5 == 0) keys[9] = ~keys[9];
            @(negedge clk);
        end
        keys[9] = 1'b1;
        exp_q.push_back(4'd9);
        wait_press(70, "bounce_press");
        check_outputs("bounce_outputs", col_out, 4'd9, 1'b1, 1'b1);
    endtask

    task automatic test_multi();
        int bad = 0;
        keys[6] = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (press !== 1'b0 || valid !== 1'b1 || buttonNum !== 4'd9) bad++;
        end
        compared++;
        if (bad != 0) begin
            mismatched++;
            $display("FAIL multi_hold: %0d bad cycles, expected 0", bad);
        end
        bad = 0;
        keys[6] = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (press !== 1'b0 || valid !== 1'b1 || buttonNum !== 4'd9) bad++;
        end
        compared++;
        if (bad != 0) begin
            mismatched++;
            $display("FAIL multi_release: %0d bad cycles, expected 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        keys[9] = 1'b0;
        wait_valid_low(67, "release_9");
        compared++;
        if (buttonNum !== 4'd9) begin
            mismatched++;
            $display("FAIL release_hold_key: got %0d, expected 9", buttonNum);
        end
        keys[15] = 1'b1;
        exp_q.push_back(4'd15);
        wait_press(67, "press_15");
        check_outputs("press_15_outputs", col_out, 4'd15, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid();
        keys[15] = 1'b0;
        wait_valid_low(67, "release_15");
        keys[3] = 1'b1;
        exp_q.push_back(4'd3);
        repeat (20) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs("reset_mid_state", 4'b1110, 4'd0, 1'b0, 1'b0);
        reset = 1'b0;
        wait_press(67, "press_3");
        check_outputs("press_3_outputs", col_out, 4'd3, 1'b1, 1'b1);
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_hold();
        test_bounce();
        test_multi();
        test_back_to_back();
        test_reset_mid();
        repeat (40) @(negedge clk);
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL press_missing: %0d queued presses never seen, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
